// File: rtl/hash_nonce_scheduler.sv
// Nonce search controller for a bank of NUM_ENG hash engines: one distinct nonce per engine
// per round, wait for all results, then report a target hit, nonce wrap, timeout or abort.
module hash_nonce_scheduler #(
   parameter int NUM_ENG = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [7:0]               target,
   input  logic [95:0]              block,
   output logic [NUM_ENG-1:0]       eng_init,
   output logic [NUM_ENG-1:0]       eng_valid,
   output logic [128*NUM_ENG-1:0]   eng_block,
   input  logic [24*NUM_ENG-1:0]    eng_hash,
   input  logic [NUM_ENG-1:0]       eng_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     found,
   output logic                     error,
   output logic                     exhausted,
   output logic [31:0]              nonce,
   output logic [31:0]              rounds,
   output logic [2:0]               dbg_state
);

   localparam int IW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DISPATCH = 3'd1,
      S_WAIT     = 3'd2,
      S_EVAL     = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [7:0]          r_target;
   logic [95:0]         r_block;
   logic [31:0]         r_base;
   logic [NUM_ENG-1:0]  r_mask;
   logic [23:0]         r_hash [NUM_ENG];
   logic [TW-1:0]       r_tmo;
   logic                r_found;
   logic                r_error;
   logic                r_exh;
   logic [31:0]         r_nonce;
   logic [31:0]         r_rounds;

   logic [NUM_ENG-1:0]  w_mask_next;
   logic                w_mask_full;
   logic                w_tmo_hit;
   logic                w_active;
   logic                w_hit_any;
   logic [IW-1:0]       w_hit_idx;
   logic [31:0]         w_hit_nonce;
   logic [32:0]         w_base_sum;

   function automatic logic [31:0] f_brev(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   assign w_mask_next = r_mask | eng_ready;
   assign w_mask_full = &w_mask_next;
   assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));
   assign w_active    = (r_state == S_DISPATCH) || (r_state == S_WAIT) || (r_state == S_EVAL);
   assign w_base_sum  = {1'b0, r_base} + 33'(NUM_ENG);
   assign w_hit_nonce = r_base + 32'(w_hit_idx);

   // Scan from the top so the lowest-index (lowest nonce) hit is the one left standing.
   always_comb begin
      w_hit_any = 1'b0;
      w_hit_idx = '0;
      for (int i = NUM_ENG - 1; i >= 0; i--) begin
         if ((r_hash[i][23:16] <= r_target) && (r_hash[i][15:8] <= r_target)) begin
            w_hit_any = 1'b1;
            w_hit_idx = IW'(i);
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (start) w_next = S_DISPATCH;
         S_DISPATCH: w_next = S_WAIT;
         S_WAIT: begin
            if (w_mask_full)    w_next = S_EVAL;
            else if (w_tmo_hit) w_next = S_DONE;
         end
         S_EVAL: begin
            if (w_hit_any || w_base_sum[32]) w_next = S_DONE;
            else                             w_next = S_DISPATCH;
         end
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
      if (abort && w_active) w_next = S_DONE;
   end

   // Engine handshake: eng_valid is high from DISPATCH through EVAL with eng_block stable;
   // eng_init marks the single cycle engines take the data; each engine's ready is taken once per round.
   always_comb begin
      eng_block = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
         if (w_active) eng_block[128*i +: 128] = {r_base + 32'(i), r_block};
      end
   end

   assign eng_init  = {NUM_ENG{r_state == S_DISPATCH}};
   assign eng_valid = {NUM_ENG{w_active}};
   assign busy      = w_active;
   assign done      = (r_state == S_DONE);
   assign found     = r_found;
   assign error     = r_error;
   assign exhausted = r_exh;
   assign nonce     = r_nonce;
   assign rounds    = r_rounds;
   assign dbg_state = r_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_target <= '0;
         r_block  <= '0;
         r_base   <= '0;
         r_mask   <= '0;
         r_tmo    <= '0;
         r_found  <= 1'b0;
         r_error  <= 1'b0;
         r_exh    <= 1'b0;
         r_nonce  <= '0;
         r_rounds <= '0;
         for (int i = 0; i < NUM_ENG; i++) r_hash[i] <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_target <= target;
                  r_block  <= block;
                  r_base   <= '0;
                  r_found  <= 1'b0;
                  r_error  <= 1'b0;
                  r_exh    <= 1'b0;
                  r_nonce  <= '0;
                  r_rounds <= '0;
               end
            end
            S_DISPATCH: begin
               r_mask <= '0;
               r_tmo  <= '0;
            end
            S_WAIT: begin
               r_mask <= w_mask_next;
               for (int i = 0; i < NUM_ENG; i++) begin
                  if (eng_ready[i] && !r_mask[i]) r_hash[i] <= eng_hash[24*i +: 24];
               end
               if (!abort && !w_mask_full) begin
                  if (w_tmo_hit) r_error <= 1'b1;
                  else           r_tmo   <= r_tmo + 1'b1;
               end
            end
            S_EVAL: begin
               if (!abort) begin
                  r_rounds <= r_rounds + 32'd1;
                  if (w_hit_any) begin
                     r_found <= 1'b1;
                     r_nonce <= f_brev(w_hit_nonce);
                  end else if (w_base_sum[32]) begin
                     r_exh <= 1'b1;
                  end else begin
                     r_base <= w_base_sum[31:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_nonce_scheduler.sv
// Bench for hash_nonce_scheduler: behavioural engine models, a reference search model that
// predicts dispatches and results, and a monitor that pops and compares when the DUT presents them.
module tb_hash_nonce_scheduler;

   localparam int NE  = 2;
   localparam int TMO = 20;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [7:0]        target = '0;
   logic [95:0]       block = '0;
   logic [NE-1:0]     eng_init;
   logic [NE-1:0]     eng_valid;
   logic [128*NE-1:0] eng_block;
   logic [24*NE-1:0]  eng_hash = '0;
   logic [NE-1:0]     eng_ready = '0;
   logic              busy, done, found, error, exhausted;
   logic [31:0]       nonce, rounds;
   logic [2:0]        dbg_state;

   always #5 clk = ~clk;

   hash_nonce_scheduler #(.NUM_ENG(NE), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target), .block(block),
      .eng_init(eng_init), .eng_valid(eng_valid), .eng_block(eng_block), .eng_hash(eng_hash),
      .eng_ready(eng_ready), .busy(busy), .done(done), .found(found), .error(error),
      .exhausted(exhausted), .nonce(nonce), .rounds(rounds), .dbg_state(dbg_state)
   );

   int            n_vec = 0;
   int            n_err = 0;
   int            hash_mode = 2;
   logic [31:0]   seed = '0;
   logic [31:0]   hit_set[$];
   logic [7:0]    cfg_target = '0;
   logic [95:0]   cfg_block = '0;
   int            lat[NE] = '{3, 3};
   bit            lvl[NE] = '{1'b0, 1'b0};
   bit            glitch[NE] = '{1'b0, 1'b0};
   int            cnt[NE] = '{0, 0};
   int            gcnt[NE] = '{0, 0};
   logic [31:0]   e_nonce[NE];
   logic [31:0]   disp_q[$];
   logic [66:0]   exp_q[$];
   logic [66:0]   last_exp = '0;
   int            exp_rounds = 0;
   logic [31:0]   force_val = '0;
   int            cyc = 0;
   int            last_init_cyc = 0;
   int            init_gap = 0;
   int            last_lat = 0;
   logic [NE-1:0] prev_init = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] hash_of(input logic [31:0] n);
      logic [31:0] x;
      if (hash_mode == 0) begin
         foreach (hit_set[k]) if (hit_set[k] == n) return 24'h000000;
         return 24'hFFFFFF;
      end else if (hash_mode == 1) begin
         x = (n ^ seed) * 32'h9E3779B1;
         x = x ^ (x >> 15);
         x = x * 32'h85EBCA77;
         x = x ^ (x >> 13);
         return x[23:0];
      end
      return 24'hFFFFFF;
   endfunction

   function automatic logic [66:0] pack(input bit f, input bit e, input bit x,
                                        input logic [31:0] n, input logic [31:0] r);
      return {f, e, x, n, r};
   endfunction

   // Reference search: plain loop over rounds of NE consecutive nonces.
   task automatic ref_run(input logic [31:0] base0, input int max_rounds, output bit ok);
      longint unsigned b;
      logic [31:0]     bases[$];
      logic [31:0]     n;
      logic [23:0]     h;
      logic [66:0]     e;
      bit              hit;
      ok = 0;
      b  = longint'(base0);
      e  = '0;
      for (int r = 1; r <= max_rounds && !ok; r++) begin
         bases.push_back(b[31:0]);
         hit = 0;
         for (int i = 0; i < NE && !hit; i++) begin
            n = b[31:0] + 32'(i);
            h = hash_of(n);
            if (h[23:16] <= cfg_target && h[15:8] <= cfg_target) begin
               hit = 1;
               e   = pack(1, 0, 0, {n[7:0], n[15:8], n[23:16], n[31:24]}, 32'(r));
            end
         end
         if (hit) ok = 1;
         else if (b + longint'(NE) > 64'hFFFF_FFFF) begin
            ok = 1;
            e  = pack(0, 0, 1, 32'h0, 32'(r));
         end
         exp_rounds = r;
         b = b + longint'(NE);
      end
      if (ok) begin
         foreach (bases[k]) disp_q.push_back(bases[k]);
         exp_q.push_back(e);
         last_exp = e;
      end
   endtask

   // Engine models: capture nonce on init, answer after lat cycles as a pulse or a level.
   always @(negedge clk) begin
      for (int i = 0; i < NE; i++) begin
         if (reset) begin
            cnt[i] = 0;
            gcnt[i] = 0;
            eng_ready[i] = 1'b0;
            eng_hash[24*i +: 24] = '0;
         end else if (eng_init[i]) begin
            e_nonce[i] = eng_block[128*i+96 +: 32];
            cnt[i] = lat[i];
            gcnt[i] = 0;
            eng_ready[i] = 1'b0;
            eng_hash[24*i +: 24] = 24'($urandom);
         end else if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
               eng_ready[i] = 1'b1;
               eng_hash[24*i +: 24] = hash_of(e_nonce[i]);
               if (glitch[i]) gcnt[i] = 3;
            end
         end else begin
            if (!lvl[i]) begin
               eng_ready[i] = 1'b0;
               eng_hash[24*i +: 24] = 24'($urandom);
            end
            if (gcnt[i] > 0) begin
               gcnt[i]--;
               if (gcnt[i] == 0) begin
                  eng_ready[i] = 1'b1;
                  eng_hash[24*i +: 24] = 24'h000000;
               end
            end
         end
      end
   end

   // Monitor: dispatches and completions are checked against the queued predictions.
   always @(negedge clk) begin
      logic [31:0] b;
      logic [66:0] e;
      if (reset) begin
         prev_init = '0;
      end else begin
         cyc++;
         if (eng_init != '0) begin
            chk("init_all", eng_init, {NE{1'b1}});
            chk("init_width", prev_init, '0);
            chk("dispatch_valid", eng_valid, {NE{1'b1}});
            if (disp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_dispatch: got base %0h expected none", eng_block[127:96]);
            end else begin
               b = disp_q.pop_front();
               for (int i = 0; i < NE; i++)
                  chk("dispatch_block", eng_block[128*i +: 128], {b + 32'(i), cfg_block});
            end
            init_gap = cyc - last_init_cyc;
            last_init_cyc = cyc;
         end
         prev_init = eng_init;
         if (done) begin
            chk("done_busy", busy, 1'b0);
            chk("done_valid", eng_valid, '0);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: got done expected none");
            end else begin
               e = exp_q.pop_front();
               chk("result", {found, error, exhausted, nonce, rounds}, e);
            end
         end
      end
   end

   task automatic run_search(input bit frc, input int budget, input bit poke);
      int c;
      @(negedge clk);
      if (frc) force dut.r_base = force_val;
      start  = 1'b1;
      target = cfg_target;
      block  = cfg_block;
      @(negedge clk);
      start  = 1'b0;
      target = 8'($urandom);
      block  = {$urandom, $urandom, $urandom};
      c = 1;
      while (!done && c < budget) begin
         @(negedge clk);
         c++;
         start = (poke && c == 5);
      end
      start = 1'b0;
      last_lat = c;
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", c);
      end
      if (frc) release dut.r_base;
      repeat (2) @(negedge clk);
      chk("result_held", {found, error, exhausted, nonce, rounds}, last_exp);
   endtask

   task automatic start_and_wait_second_init(output bit ok);
      int k;
      int c;
      @(negedge clk);
      start  = 1'b1;
      target = cfg_target;
      block  = cfg_block;
      @(negedge clk);
      start = 1'b0;
      k = (eng_init != '0) ? 1 : 0;
      c = 0;
      while (k < 2 && c < 100) begin
         @(negedge clk);
         c++;
         if (eng_init != '0) k++;
      end
      ok = (k == 2);
      chk("second_round_seen", 32'(k), 32'd2);
   endtask

   initial begin
      bit ok;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_flags", {found, error, exhausted}, 3'b000);
      chk("rst_nonce", nonce, 32'h0);
      chk("rst_rounds", rounds, 32'h0);
      chk("rst_eng", {eng_init, eng_valid}, '0);
      chk("rst_block", eng_block, '0);
      reset = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_busy", busy, 1'b0);
      chk("idle_abort_done", done, 1'b0);

      // Hit on nonce 5 in round 3; a stray start mid-search must be ignored.
      hash_mode = 0; hit_set = '{32'd5}; cfg_target = 8'h10;
      lat = '{3, 3}; lvl = '{1'b1, 1'b1}; glitch = '{1'b0, 1'b0};
      cfg_block = {$urandom, $urandom, $urandom};
      ref_run(32'h0, 50, ok);
      run_search(1'b0, 200, 1'b1);

      // Two hits in one round: lower index wins.
      hit_set = '{32'd2, 32'd3};
      lat = '{$urandom_range(1, 6), $urandom_range(1, 6)}; lvl = '{1'b0, 1'b0};
      ref_run(32'h0, 50, ok);
      run_search(1'b0, 200, 1'b0);

      // Unequal latencies with a late spurious ready carrying a hitting hash on engine 0.
      hit_set = '{32'd7}; lat = '{4, 9}; glitch = '{1'b1, 1'b0};
      ref_run(32'h0, 50, ok);
      run_search(1'b0, 200, 1'b0);
      chk("round_gap", 32'(init_gap), 32'd11);
      chk("start_to_done", 32'(last_lat), 32'd45);
      glitch = '{1'b0, 1'b0};

      // Engine 1 silent: timeout error in round 1.
      hash_mode = 2; lat = '{3, 0};
      disp_q.push_back(32'h0);
      last_exp = pack(0, 1, 0, 32'h0, 32'h0);
      exp_q.push_back(last_exp);
      run_search(1'b0, TMO + 20, 1'b0);

      // Last round of the nonce space, no hit: exhausted, no wrapped dispatch.
      lat = '{$urandom_range(1, 5), $urandom_range(1, 5)};
      force_val = 32'hFFFF_FFFE;
      ref_run(force_val, 5, ok);
      run_search(1'b1, 100, 1'b0);

      // Hit in the overflowing round: found wins over exhausted.
      hash_mode = 0; hit_set = '{32'hFFFF_FFFF};
      ref_run(force_val, 5, ok);
      run_search(1'b1, 100, 1'b0);

      // Abort during round 2 WAIT.
      hash_mode = 2; lat = '{3, 3}; lvl = '{1'b1, 1'b1};
      disp_q.push_back(32'h0);
      disp_q.push_back(32'h2);
      last_exp = pack(0, 0, 0, 32'h0, 32'h1);
      exp_q.push_back(last_exp);
      start_and_wait_second_init(ok);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_done", done, 1'b1);
      @(negedge clk);
      chk("abort_done_pulse", done, 1'b0);

      // Synchronous reset mid-WAIT of round 2.
      disp_q.push_back(32'h0);
      disp_q.push_back(32'h2);
      start_and_wait_second_init(ok);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_busy", {busy, done}, 2'b00);
      chk("mid_rst_rounds", rounds, 32'h0);
      chk("mid_rst_eng", {eng_init, eng_valid}, '0);
      chk("mid_rst_block", eng_block, '0);
      @(negedge clk);

      // Randomized searches with pseudo-random hashes.
      for (int t = 0; t < 6; t++) begin
         hash_mode = 1;
         cfg_target = 8'($urandom_range(8'h30, 8'h70));
         cfg_block = {$urandom, $urandom, $urandom};
         lat = '{$urandom_range(1, 8), $urandom_range(1, 8)};
         lvl = '{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
         ok = 0;
         for (int a = 0; a < 20 && !ok; a++) begin
            seed = $urandom;
            ref_run(32'h0, 300, ok);
         end
         if (ok) run_search(1'b0, exp_rounds * 12 + 20, 1'b0);
      end

      chk("disp_q_drained", 32'(disp_q.size()), 32'd0);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hash_nonce_scheduler.md
Name: hash_nonce_scheduler

Overview:
Controls a bank of NUM_ENG micro_ucr_hash engines during the nonce search. Each round it hands each engine a distinct nonce, pulses the engines' start together, and waits for every result. It then checks the results against the target and either reports the winning nonce or moves to the next round. It sits between the top-level start/target/block interface and the hash engines, replacing per-engine ad-hoc sequencing.

Parameters:
NUM_ENG, 2, number of hash engines driven (1..8)
TIMEOUT, 1023, max cycles spent in WAIT per round before an error abort

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  begin search; sampled only in IDLE
abort  in  1  cancel search in progress; ends in DONE with found=0
target  in  8  difficulty byte; latched at start
block  in  96  block payload; latched at start
eng_init  out  NUM_ENG  one-cycle start pulse per engine (hash_init)
eng_valid  out  NUM_ENG  data valid to engines (valid)
eng_block  out  128*NUM_ENG  engine i input at [128*i +: 128] = {nonce_i, block_r}
eng_hash  in  24*NUM_ENG  engine i hash at [24*i +: 24]
eng_ready  in  NUM_ENG  engine i hash_ready; may be a pulse or a level
busy  out  1  high from start acceptance until DONE is entered
done  out  1  one-cycle pulse when the search ends
found  out  1  valid with done and held until the next start: a hash met the target
error  out  1  valid with done and held: WAIT timed out
exhausted  out  1  valid with done and held: nonce space wrapped with no hit
nonce  out  32  winning nonce, byte-reversed from the value placed in eng_block[127:96]; held until the next start
rounds  out  32  count of completed rounds; held after done

Behaviour:
- Reset values: all outputs 0, state IDLE, base nonce 0, ready mask 0, timeout counter 0.
- States and transitions:
  - IDLE: when start=1, latch target and block, set base=0, clear found/error/exhausted/rounds/nonce, set busy=1, go to DISPATCH.
  - DISPATCH (1 cycle): drive eng_block[i] = {base+i, block_r}, assert eng_valid all ones, assert eng_init all ones for exactly this cycle. Clear ready mask and timeout counter. Go to WAIT.
  - WAIT: eng_init=0; eng_valid and eng_block are held stable. For each engine, a high eng_ready sets its mask bit and captures eng_hash[i] into a result register; the first capture wins, so later ready edges are ignored. When the mask is all ones (including bits set this cycle), go to EVAL. If timeout count reaches TIMEOUT first, go to DONE with error=1.
  - EVAL (1 cycle): rounds+1. Engine i hits when hash[23:16] <= target_r AND hash[15:8] <= target_r.
    - Lowest-index hit wins, i.e. the lowest nonce: found=1, nonce=byte-reverse(base+i), go to DONE.
    - With no hit: if base+NUM_ENG overflows 32 bits, set exhausted=1 and go to DONE. Otherwise base += NUM_ENG and go to DISPATCH.
  - DONE (1 cycle): done=1, busy=0, eng_valid=0, go to IDLE.
- Nonce arithmetic: 32-bit unsigned; base+i is computed modulo 2^32 for dispatch. The overflow check is done at 33 bits.
- Latency: start high at edge 0 puts eng_init high after edge 1. With engines of latency L (ready seen L cycles after init), one round is L+2 cycles. A hit in round 1 gives done L+3 cycles after start.
- abort:
  - Sampled in DISPATCH, WAIT and EVAL; it takes priority over every other transition.
  - Next state is DONE with found=0 and error=0.
  - Abort in IDLE is ignored.
- start outside IDLE is ignored.
- A simultaneous hit and overflow in EVAL reports found=1 and exhausted=0.
- A synchronous reset mid-search returns everything to reset values on the next edge; engines are reset by the same signal.

Test Plan:
- NUM_ENG=2, bench model hash = 24'h000000 for nonce 5 and 24'hFFFFFF otherwise, target 8'h10 -> three rounds (nonces 0-1, 2-3, 4-5), done with found=1, nonce=32'h05000000, rounds=3.
- Model returns hit for nonces 2 and 3 in the same round -> nonce=32'h02000000 (the lower index wins), rounds=2.
- Engines with different latencies (engine0 L=4, engine1 L=9), each ready a 1-cycle pulse -> EVAL entered only after engine1; captured hashes are correct; eng_init is high for exactly 1 cycle per round.
- Engine1 never asserts ready, TIMEOUT=20 -> done with error=1, found=0, busy drops the same cycle.
- Force base to 32'hFFFFFFFE, no hits -> after that round, done with exhausted=1, found=0; no dispatch with wrapped base.
- abort asserted in WAIT of round 2 -> done the next cycle with found=0, error=0, rounds=1; start re-accepted afterwards; reset mid-WAIT clears all outputs.
